// File: rtl/stark_fpu_steer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : Stark_pkg                                                        |
// | Brief   : Instruction format and opcode constants used by the FPU steerer. |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package Stark_pkg;

  // 32-bit instruction: major opcode, FP sub-op, remaining payload.
  typedef struct packed {
    logic [3:0]  op4;
    logic [23:0] payload;
    logic [3:0]  opcode;
  } instruction_t;

  localparam logic [3:0] OP_FLT    = 4'h7;
  localparam logic [3:0] FOP4_TRIG = 4'h3;
  localparam logic [3:0] FOP4_G10  = 4'h9;

endpackage

// +----------------------------------------------------------------------------+
// | Module  : stark_fpu_steer                                                  |
// | Brief   : Classifies incoming FP instructions and steers them into         |
// |           per-FPU FIFOs: special ops pinned to channel 0, general ops      |
// |           round-robin over non-full channels, non-FP ops discarded.        |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module stark_fpu_steer
  import Stark_pkg::*;
#(
  parameter int NFPU = 2,
  parameter int DEP  = 4,
  parameter int TAGW = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_v,
  output logic                                   in_rdy,
  input  instruction_t                           in_instr,
  input  logic [TAGW-1:0]                        in_tag,
  output logic [NFPU-1:0]                        out_v,
  input  logic [NFPU-1:0]                        out_rdy,
  output instruction_t [NFPU-1:0]                out_instr,
  output logic [NFPU-1:0][TAGW-1:0]              out_tag,
  output logic [NFPU-1:0][$clog2(DEP+1)-1:0]     cnt,
  output logic                                   bad_op
);

  localparam int c_CW = $clog2(DEP+1);
  localparam int c_PW = $clog2(DEP);
  localparam int c_RW = (NFPU > 1) ? $clog2(NFPU) : 1;
  localparam int c_DW = $bits(instruction_t) + TAGW;

  logic            w_is_flt;
  logic            w_f0;
  logic            w_fg;
  logic            w_nf;
  logic            w_acc;
  logic [NFPU-1:0] w_full;
  logic            w_found;
  logic [c_RW-1:0] w_sel;
  logic [c_RW-1:0] w_rr_nxt;
  logic [c_RW-1:0] r_rr;
  logic            r_bad_op;

  assign w_is_flt = (in_instr.opcode == OP_FLT);
  assign w_f0     = w_is_flt && ((in_instr.op4 == FOP4_TRIG) || (in_instr.op4 == FOP4_G10));
  assign w_fg     = w_is_flt && !w_f0;
  assign w_nf     = !w_is_flt;

  // A flush cycle swallows nothing: the presented input is simply not taken.
  assign w_acc    = in_v && in_rdy && !flush;

  // First non-full channel at or above rr, then wrap to the channels below rr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int c = 0; c < NFPU; c++) begin
      if (!w_found && (c >= int'(r_rr)) && !w_full[c]) begin
        w_found = 1'b1;
        w_sel   = c_RW'(c);
      end
    end
    for (int c = 0; c < NFPU; c++) begin
      if (!w_found && (c < int'(r_rr)) && !w_full[c]) begin
        w_found = 1'b1;
        w_sel   = c_RW'(c);
      end
    end
  end

  // Pointer advances one past the chosen channel, wrapping at NFPU.
  always_comb begin
    w_rr_nxt = '0;
    if (w_sel != c_RW'(NFPU-1)) begin
      w_rr_nxt = w_sel + c_RW'(1);
    end
  end

  // Readiness depends only on queue state and input class, never on out_rdy.
  always_comb begin
    in_rdy = 1'b1;
    if (w_f0) begin
      in_rdy = !w_full[0];
    end else if (w_fg) begin
      in_rdy = w_found;
    end
  end

  // Round-robin pointer moves only on general-class accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
    end else if (flush) begin
      r_rr <= '0;
    end else if (w_acc && w_fg) begin
      r_rr <= w_rr_nxt;
    end
  end

  // One-cycle pulse when a non-FP instruction is accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad_op <= 1'b0;
    end else if (flush) begin
      r_bad_op <= 1'b0;
    end else begin
      r_bad_op <= w_acc && w_nf;
    end
  end

  assign bad_op = r_bad_op;

  for (genvar c = 0; c < NFPU; c++) begin : g_ch
    logic [c_DW-1:0] r_mem [DEP];
    logic [c_PW-1:0] r_wp;
    logic [c_PW-1:0] r_rp;
    logic [c_CW-1:0] r_cnt;
    logic [c_DW-1:0] w_head;
    logic            w_push;
    logic            w_pop;

    assign w_push = w_acc && ((w_f0 && (c == 0)) || (w_fg && (int'(w_sel) == c)));
    assign w_pop  = out_v[c] && out_rdy[c];

    assign w_full[c]    = (r_cnt == c_CW'(DEP));
    assign out_v[c]     = (r_cnt != '0);
    assign cnt[c]       = r_cnt;
    assign w_head       = r_mem[r_rp];
    assign out_instr[c] = instruction_t'(w_head[c_DW-1:TAGW]);
    assign out_tag[c]   = w_head[TAGW-1:0];

    // Entry storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wp] <= {in_instr, in_tag};
      end
    end

    // Pointers wrap naturally since DEP is a power of two.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else if (flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) begin
          r_wp <= r_wp + c_PW'(1);
        end
        if (w_pop) begin
          r_rp <= r_rp + c_PW'(1);
        end
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + c_CW'(1);
        end else if (!w_push && w_pop) begin
          r_cnt <= r_cnt - c_CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stark_fpu_steer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stark_fpu_steer                                               |
// | Brief   : Directed self-checking bench for stark_fpu_steer (NFPU=2,DEP=4). |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_stark_fpu_steer;
  import Stark_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   in_v;
  logic                   in_rdy;
  instruction_t           in_instr;
  logic [5:0]             in_tag;
  logic [1:0]             out_v;
  logic [1:0]             out_rdy;
  instruction_t [1:0]     out_instr;
  logic [1:0][5:0]        out_tag;
  logic [1:0][2:0]        cnt;
  logic                   bad_op;

  int total = 0;
  int bad   = 0;

  stark_fpu_steer #(.NFPU(2), .DEP(4), .TAGW(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_v     (in_v),
    .in_rdy   (in_rdy),
    .in_instr (in_instr),
    .in_tag   (in_tag),
    .out_v    (out_v),
    .out_rdy  (out_rdy),
    .out_instr(out_instr),
    .out_tag  (out_tag),
    .cnt      (cnt),
    .bad_op   (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic instruction_t mk_f0(input logic [23:0] p, input logic g10);
    instruction_t t;
    t.opcode  = OP_FLT;
    t.op4     = g10 ? FOP4_G10 : FOP4_TRIG;
    t.payload = p;
    return t;
  endfunction

  function automatic instruction_t mk_fg(input logic [23:0] p);
    instruction_t t;
    t.opcode  = OP_FLT;
    t.op4     = 4'h1;
    t.payload = p;
    return t;
  endfunction

  function automatic instruction_t mk_nf(input logic [23:0] p);
    instruction_t t;
    t.opcode  = 4'h2;
    t.op4     = FOP4_TRIG;
    t.payload = p;
    return t;
  endfunction

  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL reset_cnt0: got %0d want 0", cnt[0]); end
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL reset_cnt1: got %0d want 0", cnt[1]); end
    total++; if (out_v !== 2'b00) begin bad++; $display("FAIL reset_out_v: got %b want 00", out_v); end
    total++; if (bad_op !== 1'b0) begin bad++; $display("FAIL reset_bad_op: got %b want 0", bad_op); end
    in_instr = mk_f0(24'h1, 1'b0); #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_f0: got %b want 1", in_rdy); end
    in_instr = mk_fg(24'h1); #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_fg: got %b want 1", in_rdy); end
    in_instr = mk_nf(24'h1); #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_nf: got %b want 1", in_rdy); end
  endtask

  task automatic test_fg_rr;
    out_rdy = 2'b00;
    for (int t = 1; t <= 4; t++) begin
      in_v = 1'b1; in_instr = mk_fg(24'(t * 100)); in_tag = 6'(t);
      tick;
      if (t == 1) begin
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL fg_latency_v: got %b want 01", out_v); end
      end
    end
    in_v = 1'b0;
    total++; if (cnt[0] !== 3'd2) begin bad++; $display("FAIL fg_cnt0: got %0d want 2", cnt[0]); end
    total++; if (cnt[1] !== 3'd2) begin bad++; $display("FAIL fg_cnt1: got %0d want 2", cnt[1]); end
    total++; if (out_tag[0] !== 6'd1) begin bad++; $display("FAIL fg_head0: got %0d want 1", out_tag[0]); end
    total++; if (out_tag[1] !== 6'd2) begin bad++; $display("FAIL fg_head1: got %0d want 2", out_tag[1]); end
    total++; if (out_instr[1].payload !== 24'd200) begin bad++; $display("FAIL fg_payload1: got %0d want 200", out_instr[1].payload); end
    out_rdy = 2'b01; tick; out_rdy = 2'b00;
    total++; if (out_tag[0] !== 6'd3) begin bad++; $display("FAIL fg_pop0: got %0d want 3", out_tag[0]); end
    total++; if (cnt[0] !== 3'd1) begin bad++; $display("FAIL fg_pop0_cnt: got %0d want 1", cnt[0]); end
    out_rdy = 2'b10; tick; out_rdy = 2'b00;
    total++; if (out_tag[1] !== 6'd4) begin bad++; $display("FAIL fg_pop1: got %0d want 4", out_tag[1]); end
    flush = 1'b1; tick; flush = 1'b0;
    total++; if (cnt !== 6'd0) begin bad++; $display("FAIL fg_flush_cnt: got %h want 0", cnt); end
  endtask

  task automatic test_f0_full;
    out_rdy = 2'b00;
    for (int t = 1; t <= 4; t++) begin
      in_v = 1'b1; in_instr = mk_f0(24'(t), t[0]); in_tag = 6'(t);
      tick;
    end
    in_instr = mk_f0(24'd5, 1'b0); in_tag = 6'd5; #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL f0_full_rdy: got %b want 0", in_rdy); end
    total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL f0_full_cnt: got %0d want 4", cnt[0]); end
    tick;
    total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL f0_refused_cnt: got %0d want 4", cnt[0]); end
    out_rdy = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      total++; if (out_tag[0] !== 6'(i)) begin bad++; $display("FAIL f0_drain_order: got %0d want %0d", out_tag[0], i); end
      if (i == 1) begin
        total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL f0_rdy_still_full: got %b want 0", in_rdy); end
      end
      if (i == 2) begin
        total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL f0_rdy_after_pop: got %b want 1", in_rdy); end
      end
      tick;
      if (i == 2) in_v = 1'b0;
    end
    out_rdy = 2'b00;
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL f0_drained_cnt: got %0d want 0", cnt[0]); end
    total++; if (cnt[1] !== 3'd0) begin bad++; $display("FAIL f0_ch1_untouched: got %0d want 0", cnt[1]); end
  endtask

  task automatic test_fg_skip;
    for (int t = 10; t <= 13; t++) begin
      in_v = 1'b1; in_instr = mk_f0(24'(t), 1'b1); in_tag = 6'(t);
      tick;
    end
    in_instr = mk_fg(24'd20); in_tag = 6'd20; #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL skip_fg_rdy: got %b want 1", in_rdy); end
    tick;
    total++; if (cnt[1] !== 3'd1) begin bad++; $display("FAIL skip_fg_cnt1: got %0d want 1", cnt[1]); end
    total++; if (out_tag[1] !== 6'd20) begin bad++; $display("FAIL skip_fg_tag1: got %0d want 20", out_tag[1]); end
    in_instr = mk_f0(24'd21, 1'b0); in_tag = 6'd21; #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL skip_f0_rdy: got %b want 0", in_rdy); end
    tick;
    in_v = 1'b0;
    total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL skip_f0_cnt0: got %0d want 4", cnt[0]); end
  endtask

  task automatic test_back_to_back;
    out_rdy = 2'b01;
    in_v = 1'b1; in_instr = mk_fg(24'd22); in_tag = 6'd22;
    tick;
    out_rdy = 2'b00;
    total++; if (cnt[0] !== 3'd3) begin bad++; $display("FAIL b2b_cnt0: got %0d want 3", cnt[0]); end
    total++; if (cnt[1] !== 3'd2) begin bad++; $display("FAIL b2b_cnt1: got %0d want 2", cnt[1]); end
    total++; if (out_tag[0] !== 6'd11) begin bad++; $display("FAIL b2b_head0: got %0d want 11", out_tag[0]); end
    // rr should have returned to 0, so the next general op lands in channel 0.
    in_instr = mk_fg(24'd23); in_tag = 6'd23;
    tick;
    in_v = 1'b0;
    total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL b2b_rr_cnt0: got %0d want 4", cnt[0]); end
    total++; if (cnt[1] !== 3'd2) begin bad++; $display("FAIL b2b_rr_cnt1: got %0d want 2", cnt[1]); end
  endtask

  task automatic test_bad_op;
    in_v = 1'b1; in_instr = mk_nf(24'd30); in_tag = 6'd30; #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL nf_rdy: got %b want 1", in_rdy); end
    tick;
    in_v = 1'b0;
    total++; if (bad_op !== 1'b1) begin bad++; $display("FAIL nf_pulse: got %b want 1", bad_op); end
    total++; if (cnt[0] !== 3'd4 || cnt[1] !== 3'd2) begin bad++; $display("FAIL nf_cnt: got %0d/%0d want 4/2", cnt[0], cnt[1]); end
    tick;
    total++; if (bad_op !== 1'b0) begin bad++; $display("FAIL nf_pulse_end: got %b want 0", bad_op); end
  endtask

  task automatic test_flush;
    flush = 1'b1; in_v = 1'b1; in_instr = mk_fg(24'd40); in_tag = 6'd40;
    tick;
    flush = 1'b0; in_v = 1'b0;
    total++; if (cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt: got %h want 0", cnt); end
    total++; if (out_v !== 2'b00) begin bad++; $display("FAIL flush_out_v: got %b want 00", out_v); end
    // rr was 1 before the flush; a cleared rr sends this op to channel 0.
    in_v = 1'b1; in_instr = mk_fg(24'd41); in_tag = 6'd41;
    tick;
    in_instr = mk_fg(24'd42); in_tag = 6'd42;
    tick;
    in_v = 1'b0;
    total++; if (out_tag[0] !== 6'd41 || cnt[0] !== 3'd1) begin bad++; $display("FAIL flush_rr: got tag %0d cnt %0d want 41/1", out_tag[0], cnt[0]); end
    total++; if (out_tag[1] !== 6'd42 || cnt[1] !== 3'd1) begin bad++; $display("FAIL flush_rr1: got tag %0d cnt %0d want 42/1", out_tag[1], cnt[1]); end
    #2 rst = 1'b1;
    #1;
    total++; if (cnt !== 6'd0) begin bad++; $display("FAIL areset_cnt: got %h want 0", cnt); end
    total++; if (out_v !== 2'b00) begin bad++; $display("FAIL areset_out_v: got %b want 00", out_v); end
    tick;
    rst = 1'b0;
    tick;
    total++; if (out_v !== 2'b00) begin bad++; $display("FAIL areset_no_reappear: got %b want 00", out_v); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_v = 1'b0; out_rdy = 2'b00;
    in_instr = mk_nf(24'd0); in_tag = 6'd0;
    tick; tick;
    rst = 1'b0;
    test_reset;
    test_fg_rr;
    test_f0_full;
    test_fg_skip;
    test_back_to_back;
    test_bad_op;
    test_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
